// File: rtl/bf_result_reader.sv
// Host-side reader for the Bellman-Ford datapath: runs the datapath, snapshots
// the distance vector on finish, then streams it out word by word (valid/ready).
module bf_result_reader #(
    parameter int unsigned       N_NODES        = 16,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       IDX_W          = 4,
    parameter logic [DATA_W-1:0] INF_VALUE      = DATA_W'(32'h7FFF_FFFF),
    parameter int unsigned       TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_global,
    input  logic                      start,
    input  logic                      finish,
    input  logic [N_NODES*DATA_W-1:0] d_bus,
    output logic                      read_enable,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_index,
    output logic                      out_last,
    output logic                      out_unreach,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout
);

    localparam int unsigned      CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NODES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_index, w_index_nxt;
    logic [DATA_W-1:0]  r_data, w_data_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_last, w_last_nxt;
    logic               r_unreach, w_unreach_nxt;
    logic               r_rd_en, w_rd_en_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic               w_snap_load;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [DATA_W-1:0]  w_word0;
    logic [DATA_W-1:0]  w_word_inc;
    logic [DATA_W-1:0]  r_snap [N_NODES];

    assign w_idx_inc  = r_index + IDX_W'(1);
    assign w_word0    = d_bus[DATA_W-1:0];
    assign w_word_inc = r_snap[w_idx_inc];

    // Next-state and next-output logic; registers hold unless overridden.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_index_nxt   = r_index;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_last_nxt    = r_last;
        w_unreach_nxt = r_unreach;
        w_rd_en_nxt   = r_rd_en;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;
        w_snap_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_rd_en_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_RUN: begin
                if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CNT_W'(1);
                // finish has priority over a timeout firing on the same edge
                if (finish) begin
                    w_state_nxt   = S_STREAM;
                    w_snap_load   = 1'b1;
                    w_rd_en_nxt   = 1'b0;
                    w_valid_nxt   = 1'b1;
                    w_index_nxt   = '0;
                    w_data_nxt    = w_word0;
                    w_unreach_nxt = (w_word0 == INF_VALUE);
                    w_last_nxt    = (LAST_IDX == '0);
                end else if (TO_EN && (r_cnt == TO_LAST)) begin
                    w_state_nxt = S_IDLE;
                    w_rd_en_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (r_index == LAST_IDX) begin
                        w_state_nxt   = S_DONE;
                        w_valid_nxt   = 1'b0;
                        w_last_nxt    = 1'b0;
                        w_unreach_nxt = 1'b0;
                        w_data_nxt    = '0;
                        w_index_nxt   = '0;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_index_nxt   = w_idx_inc;
                        w_data_nxt    = w_word_inc;
                        w_unreach_nxt = (w_word_inc == INF_VALUE);
                        w_last_nxt    = (w_idx_inc == LAST_IDX);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_global) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_index   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_unreach <= 1'b0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_index   <= w_index_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
            r_unreach <= w_unreach_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Snapshot is pure data; it is only read while streaming after a load.
    always_ff @(posedge clk) begin
        if (w_snap_load) begin
            for (int unsigned i = 0; i < N_NODES; i++) begin
                r_snap[i] <= d_bus[i*DATA_W +: DATA_W];
            end
        end
    end

    assign read_enable = r_rd_en;
    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign out_index   = r_index;
    assign out_last    = r_last;
    assign out_unreach = r_unreach;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_bf_result_reader.sv
// Bench for bf_result_reader: table-driven runs, randomized runs against a
// snapshot/queue reference model, and hand sequences for timeout corners.
module tb_bf_result_reader;

    localparam int unsigned N   = 16;
    localparam int unsigned DW  = 32;
    localparam logic [31:0] INF = 32'h7FFF_FFFF;

    logic          clk;
    logic          rst_global, start, finish, out_ready;
    logic [N*DW-1:0] d_bus;

    logic        read_enable, out_valid, out_last, out_unreach, busy, done, err_timeout;
    logic [31:0] out_data;
    logic [3:0]  out_index;

    logic        t_read_enable, t_out_valid, t_out_last, t_out_unreach, t_busy, t_done, t_err;
    logic [31:0] t_out_data;
    logic [3:0]  t_out_index;

    int n_cmp;
    int n_bad;

    bf_result_reader u_dut (
        .clk(clk), .rst_global(rst_global), .start(start), .finish(finish), .d_bus(d_bus),
        .read_enable(read_enable), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .out_unreach(out_unreach), .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    bf_result_reader #(.TIMEOUT_CYCLES(8)) u_to (
        .clk(clk), .rst_global(rst_global), .start(start), .finish(finish), .d_bus(d_bus),
        .read_enable(t_read_enable), .out_valid(t_out_valid), .out_ready(out_ready),
        .out_data(t_out_data), .out_index(t_out_index), .out_last(t_out_last),
        .out_unreach(t_out_unreach), .busy(t_busy), .done(t_done), .err_timeout(t_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        int          run_len;
        logic [3:0]  rdy_pat;
        int          pat;
        bit          disturb;
        int          rst_beat;
        logic [15:0] exp_mask;
        logic [31:0] exp_d0;
        logic [31:0] exp_d15;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] make_bus(input int pat);
        logic [N*DW-1:0] b;
        for (int i = 0; i < N; i++) begin
            if (pat == 0)                b[i*DW +: DW] = 32'(i * 5);
            else if (i == 3 || i == 9)   b[i*DW +: DW] = INF;
            else                         b[i*DW +: DW] = 32'd1;
        end
        return b;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_rd_en"},   32'(read_enable), 32'd0);
        chk({tag, "_valid"},   32'(out_valid),   32'd0);
        chk({tag, "_last"},    32'(out_last),    32'd0);
        chk({tag, "_unreach"}, 32'(out_unreach), 32'd0);
        chk({tag, "_busy"},    32'(busy),        32'd0);
        chk({tag, "_done"},    32'(done),        32'd0);
        chk({tag, "_err"},     32'(err_timeout), 32'd0);
        chk({tag, "_data"},    out_data,         32'd0);
        chk({tag, "_index"},   32'(out_index),   32'd0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_global = 1'b1; start = 1'b0; finish = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_global = 1'b0;
    endtask

    // One full run on u_dut; the model is the word array captured when finish is driven.
    task automatic run_case(input int run_len, input logic [3:0] rdy_pat, input bit rand_rdy,
                            input logic [N*DW-1:0] bus, input bit disturb, input int rst_beat,
                            output logic [15:0] mask, output logic [31:0] first_w,
                            output logic [31:0] last_w);
        logic [31:0] exp_w [N];
        int   k;
        int   cyc;
        logic rdy;
        mask = '0; first_w = '0; last_w = '0;
        d_bus = bus;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= run_len; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("run_rd_en", 32'(read_enable), 32'd1);
            chk("run_busy",  32'(busy),        32'd1);
            chk("run_valid", 32'(out_valid),   32'd0);
            if (i == run_len) finish = 1'b1;
        end
        for (int i = 0; i < N; i++) exp_w[i] = bus[i*DW +: DW];
        k = 0; cyc = 0;
        while (k < N && cyc < 200) begin
            @(negedge clk);
            finish = 1'b0;
            chk("str_valid",   32'(out_valid),   32'd1);
            chk("str_rd_en",   32'(read_enable), 32'd0);
            chk("str_index",   32'(out_index),   32'(k));
            chk("str_data",    out_data,         exp_w[k]);
            chk("str_last",    32'(out_last),    32'(k == N - 1));
            chk("str_unreach", 32'(out_unreach), 32'(exp_w[k] == INF));
            if (out_unreach) mask[k] = 1'b1;
            if (k == 0)      first_w = out_data;
            if (k == N - 1)  last_w  = out_data;
            if (rst_beat == k) begin
                rst_global = 1'b1; out_ready = 1'b0;
                @(negedge clk);
                rst_global = 1'b0;
                check_reset("rst_mid");
                return;
            end
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_pat[cyc % 4];
            out_ready = rdy;
            if (disturb) begin
                for (int i = 0; i < N; i++) d_bus[i*DW +: DW] = $urandom();
                finish = 1'($urandom_range(0, 1));
                start  = 1'($urandom_range(0, 1));
            end
            if (rdy) k++;
            cyc++;
        end
        if (k < N) chk("stream_budget", 32'(k), 32'(N));
        @(negedge clk);
        out_ready = 1'b0; finish = 1'b0;
        chk("done_pulse", 32'(done),      32'd1);
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_busy",  32'(busy),      32'd1);
        start = disturb;
        @(negedge clk);
        start = 1'b0;
        chk("idle_done",  32'(done),        32'd0);
        chk("idle_busy",  32'(busy),        32'd0);
        chk("idle_rd_en", 32'(read_enable), 32'd0);
    endtask

    vec_t            tbl [6];
    logic [15:0]     mask, exp_mask;
    logic [31:0]     w0, w15;
    logic [N*DW-1:0] rbus;
    int              cnt_re;
    bit              saw_valid;

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_global = 1'b1; start = 1'b0; finish = 1'b0; out_ready = 1'b0; d_bus = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        chk("por_to_busy", 32'(t_busy), 32'd0);
        rst_global = 1'b0;

        tbl[0] = '{10, 4'b1111, 0, 1'b0, -1, 16'h0000, 32'd0, 32'd75};
        tbl[1] = '{10, 4'b1001, 0, 1'b0, -1, 16'h0000, 32'd0, 32'd75};
        tbl[2] = '{5,  4'b1111, 1, 1'b0, -1, 16'h0208, 32'd1, 32'd1};
        tbl[3] = '{3,  4'b1011, 0, 1'b1, -1, 16'h0000, 32'd0, 32'd75};
        tbl[4] = '{10, 4'b1111, 0, 1'b0,  7, 16'h0000, 32'd0, 32'd0};
        tbl[5] = '{1,  4'b1111, 1, 1'b0, -1, 16'h0208, 32'd1, 32'd1};
        for (int v = 0; v < 6; v++) begin
            run_case(tbl[v].run_len, tbl[v].rdy_pat, 1'b0, make_bus(tbl[v].pat),
                     tbl[v].disturb, tbl[v].rst_beat, mask, w0, w15);
            chk("tbl_mask", 32'(mask), 32'(tbl[v].exp_mask));
            chk("tbl_d0",   w0,        tbl[v].exp_d0);
            chk("tbl_d15",  w15,       tbl[v].exp_d15);
        end

        for (int r = 0; r < 8; r++) begin
            exp_mask = '0;
            for (int i = 0; i < N; i++) begin
                rbus[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? INF : $urandom();
                if (rbus[i*DW +: DW] == INF) exp_mask[i] = 1'b1;
            end
            run_case(int'($urandom_range(1, 20)), 4'b0000, 1'b1, rbus, r[0], -1, mask, w0, w15);
            chk("rnd_mask", 32'(mask), 32'(exp_mask));
        end

        // finish on the very cycle the 8-cycle timeout would fire
        rst_pulse();
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 8) finish = 1'b1;
        end
        @(negedge clk);
        finish = 1'b0;
        chk("fw_valid", 32'(t_out_valid),   32'd1);
        chk("fw_err",   32'(t_err),         32'd0);
        chk("fw_rd_en", 32'(t_read_enable), 32'd0);

        // plain timeout, then a restart clears the sticky error
        rst_pulse();
        d_bus = make_bus(0);
        @(negedge clk);
        start = 1'b1;
        cnt_re = 0; saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (t_read_enable) cnt_re++;
            if (t_out_valid) saw_valid = 1'b1;
            if (!t_busy) break;
        end
        chk("to_len",     32'(cnt_re),        32'd8);
        chk("to_err",     32'(t_err),         32'd1);
        chk("to_novalid", 32'(saw_valid),     32'd0);
        chk("to_idle",    32'(t_busy),        32'd0);
        @(negedge clk);
        chk("to_err_hold", 32'(t_err), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("to_err_clr", 32'(t_err),         32'd0);
        chk("to_restart", 32'(t_read_enable), 32'd1);
        rst_pulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
